// File: rtl/hazard_ctrl.sv
// ID-stage hazard controller: load-use stalls, mult/div HI/LO scoreboard and branch flushes.
// Optional stall performance counter enabled by defining HAZ_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       Rreg_addr12,
  input  logic [4:0]       Rreg_addr22,
  input  logic             UsesRs2,
  input  logic             UsesRt2,
  input  logic             MulDiv2,
  input  logic             HiLoRead2,
  input  logic             MemRead3,
  input  logic             RegWrite3,
  input  logic [4:0]       Wreg_addr3,
  input  logic             BranchTaken3,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXBubble,
  output logic             MulDivStart,
  output logic             HiLoWe,
  output logic             MulDivBusy,
  output logic [CNT_W-1:0] StallCount
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(MULDIV_LAT - 1);

  state_t     state_r;
  logic [3:0] cnt_r;
  logic       busy_r;
  logic       hilowe_r;

  logic       lu_s;
  logic       md_s;
  logic       stall_s;
  logic       issue_s;

  // Hazard detection terms derived from the ID/EX contents and the scoreboard state.
  always_comb begin
    lu_s    = 1'b0;
    if (MemRead3 && RegWrite3 && (Wreg_addr3 != 5'd0)) begin
      lu_s = (UsesRs2 && (Rreg_addr12 == Wreg_addr3)) ||
             (UsesRt2 && (Rreg_addr22 == Wreg_addr3));
    end else begin
      lu_s = 1'b0;
    end
    md_s    = (state_r != IDLE) && (MulDiv2 || HiLoRead2);
    stall_s = (lu_s || md_s) && !BranchTaken3;
    issue_s = MulDiv2 && (state_r == IDLE) && !lu_s && !BranchTaken3;
  end

  // Pipeline control outputs; a taken branch overrides any stall because the ID instruction dies.
  always_comb begin
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IFIDFlush  = 1'b0;
    IDEXBubble = 1'b0;
    if (BranchTaken3) begin
      PCWrite    = 1'b1;
      IFIDWrite  = 1'b1;
      IFIDFlush  = 1'b1;
      IDEXBubble = 1'b1;
    end else if (stall_s) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IFIDFlush  = 1'b0;
      IDEXBubble = 1'b1;
    end else begin
      PCWrite    = 1'b1;
      IFIDWrite  = 1'b1;
      IFIDFlush  = 1'b0;
      IDEXBubble = 1'b0;
    end
  end

  assign MulDivStart = issue_s;
  assign MulDivBusy  = busy_r;
  assign HiLoWe      = hilowe_r;

  // Mult/div scoreboard FSM; busy/HI-LO-write flags are registered alongside the state.
  // Branches are deliberately ignored once BUSY: the in-flight op is older than the branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= 4'd0;
      busy_r   <= 1'b0;
      hilowe_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (issue_s) begin
            state_r  <= BUSY;
            cnt_r    <= CNT_LOAD;
            busy_r   <= 1'b1;
            hilowe_r <= 1'b0;
          end else begin
            state_r  <= IDLE;
            cnt_r    <= 4'd0;
            busy_r   <= 1'b0;
            hilowe_r <= 1'b0;
          end
        end
        BUSY: begin
          if (cnt_r == 4'd0) begin
            state_r  <= DONE;
            cnt_r    <= 4'd0;
            busy_r   <= 1'b1;
            hilowe_r <= 1'b1;
          end else begin
            state_r  <= BUSY;
            cnt_r    <= cnt_r - 4'd1;
            busy_r   <= 1'b1;
            hilowe_r <= 1'b0;
          end
        end
        DONE: begin
          state_r  <= IDLE;
          cnt_r    <= 4'd0;
          busy_r   <= 1'b0;
          hilowe_r <= 1'b0;
        end
        default: begin
          state_r  <= IDLE;
          cnt_r    <= 4'd0;
          busy_r   <= 1'b0;
          hilowe_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_r;

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign StallCount = stall_cnt_r;
`else
  assign StallCount = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MULDIV_LAT=4, CNT_W=4).
module tb_hazard_ctrl;

  localparam int LAT = 4;
  localparam int CW  = 4;
`ifdef HAZ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    Rreg_addr12, Rreg_addr22, Wreg_addr3;
  logic          UsesRs2, UsesRt2, MulDiv2, HiLoRead2;
  logic          MemRead3, RegWrite3, BranchTaken3;
  logic          PCWrite, IFIDWrite, IFIDFlush, IDEXBubble;
  logic          MulDivStart, HiLoWe, MulDivBusy;
  logic [CW-1:0] StallCount;

  int n_cmp = 0;
  int n_err = 0;
  int exp_sc = 0;

  hazard_ctrl #(.MULDIV_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rreg_addr12(Rreg_addr12), .Rreg_addr22(Rreg_addr22),
    .UsesRs2(UsesRs2), .UsesRt2(UsesRt2),
    .MulDiv2(MulDiv2), .HiLoRead2(HiLoRead2),
    .MemRead3(MemRead3), .RegWrite3(RegWrite3), .Wreg_addr3(Wreg_addr3),
    .BranchTaken3(BranchTaken3),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush),
    .IDEXBubble(IDEXBubble), .MulDivStart(MulDivStart), .HiLoWe(HiLoWe),
    .MulDivBusy(MulDivBusy), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic haz(input string tag, input logic pc, input logic ifid,
                     input logic fl, input logic bub);
    check({tag, ".PCWrite"},    {31'd0, PCWrite},    {31'd0, pc});
    check({tag, ".IFIDWrite"},  {31'd0, IFIDWrite},  {31'd0, ifid});
    check({tag, ".IFIDFlush"},  {31'd0, IFIDFlush},  {31'd0, fl});
    check({tag, ".IDEXBubble"}, {31'd0, IDEXBubble}, {31'd0, bub});
  endtask

  task automatic chk_sc(input string tag);
    check(tag, {28'd0, StallCount}, PERF ? exp_sc : 32'd0);
  endtask

  // Advance one clock; the model counts the stall that this edge retires.
  task automatic tick(input bit stalled);
    if (stalled && exp_sc < 15) exp_sc++;
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    Rreg_addr12 = 5'd0; Rreg_addr22 = 5'd0; Wreg_addr3 = 5'd0;
    UsesRs2 = 1'b0; UsesRt2 = 1'b0; MulDiv2 = 1'b0; HiLoRead2 = 1'b0;
    MemRead3 = 1'b0; RegWrite3 = 1'b0; BranchTaken3 = 1'b0;
  endtask

  task automatic load_use_rs8();
    clr();
    MemRead3 = 1'b1; RegWrite3 = 1'b1; Wreg_addr3 = 5'd8;
    UsesRs2 = 1'b1; Rreg_addr12 = 5'd8;
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    #3;
    haz("rst", 1'b1, 1'b1, 1'b0, 1'b0);
    check("rst.busy",  {31'd0, MulDivBusy},  32'd0);
    check("rst.hilo",  {31'd0, HiLoWe},      32'd0);
    check("rst.start", {31'd0, MulDivStart}, 32'd0);
    chk_sc("rst.sc");
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(1'b0);

    // Load-use on rs: one stall, then the load has left EX.
    load_use_rs8(); #1;
    haz("lu_rs", 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b1);
    clr(); UsesRs2 = 1'b1; Rreg_addr12 = 5'd8; #1;
    haz("lu_after", 1'b1, 1'b1, 1'b0, 1'b0);
    chk_sc("lu.sc");
    tick(1'b0);

    // Load to $zero never stalls.
    clr(); MemRead3 = 1'b1; RegWrite3 = 1'b1; UsesRs2 = 1'b1; #1;
    haz("lu_zero", 1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b0);

    // rt match stalls only when rt is actually read.
    clr(); MemRead3 = 1'b1; RegWrite3 = 1'b1; Wreg_addr3 = 5'd9; Rreg_addr22 = 5'd9; #1;
    haz("lu_rt_unused", 1'b1, 1'b1, 1'b0, 1'b0);
    UsesRt2 = 1'b1; #1;
    haz("lu_rt", 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b1);

    // Non-load writer with matching register is forwarded, not stalled.
    clr(); RegWrite3 = 1'b1; Wreg_addr3 = 5'd8; UsesRs2 = 1'b1; Rreg_addr12 = 5'd8; #1;
    haz("alu_fwd", 1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b0);

    // Flush wins over load-use and is not counted as a stall.
    load_use_rs8(); BranchTaken3 = 1'b1; #1;
    haz("flush_lu", 1'b1, 1'b1, 1'b1, 1'b1);
    tick(1'b0);
    clr(); #1;
    chk_sc("flush.sc");

    // A mult behind a load-use is held, not issued.
    load_use_rs8(); MulDiv2 = 1'b1; #1;
    check("md_lu.start", {31'd0, MulDivStart}, 32'd0);
    haz("md_lu", 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b1);

    // Mult issues in cycle 0, mflo waits in ID through DONE.
    clr(); MulDiv2 = 1'b1; #1;
    check("mc0.start", {31'd0, MulDivStart}, 32'd1);
    check("mc0.busy",  {31'd0, MulDivBusy},  32'd0);
    haz("mc0", 1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b0);
    clr(); HiLoRead2 = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      #1;
      haz($sformatf("mc%0d", c), 1'b0, 1'b0, 1'b0, 1'b1);
      check($sformatf("mc%0d.busy", c), {31'd0, MulDivBusy}, 32'd1);
      check($sformatf("mc%0d.hilo", c), {31'd0, HiLoWe}, (c == 5) ? 32'd1 : 32'd0);
      tick(1'b1);
    end
    #1;
    haz("mc6", 1'b1, 1'b1, 1'b0, 1'b0);
    check("mc6.busy", {31'd0, MulDivBusy}, 32'd0);
    check("mc6.hilo", {31'd0, HiLoWe},     32'd0);
    chk_sc("mc.sc");
    tick(1'b0);

    // Branch flush in cycle 2 of a mult does not abort it.
    clr(); MulDiv2 = 1'b1; #1;
    check("fb0.start", {31'd0, MulDivStart}, 32'd1);
    tick(1'b0);
    clr(); #1;
    haz("fb1", 1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b0);
    BranchTaken3 = 1'b1; MulDiv2 = 1'b1; #1;
    haz("fb2", 1'b1, 1'b1, 1'b1, 1'b1);
    check("fb2.start", {31'd0, MulDivStart}, 32'd0);
    tick(1'b0);
    BranchTaken3 = 1'b0; #1;
    check("fb3.start", {31'd0, MulDivStart}, 32'd0);
    haz("fb3", 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b1);
    clr(); #1;
    check("fb4.hilo", {31'd0, HiLoWe}, 32'd0);
    tick(1'b0);
    check("fb5.hilo", {31'd0, HiLoWe},     32'd1);
    check("fb5.busy", {31'd0, MulDivBusy}, 32'd1);
    tick(1'b0);
    check("fb6.busy", {31'd0, MulDivBusy}, 32'd0);

    // Reset in cycle 2 of a mult drops it immediately, no HI/LO write.
    MulDiv2 = 1'b1; #1;
    tick(1'b0);
    clr();
    tick(1'b0);
    rst_n = 1'b0; exp_sc = 0; #1;
    check("rb.busy", {31'd0, MulDivBusy}, 32'd0);
    check("rb.hilo", {31'd0, HiLoWe},     32'd0);
    chk_sc("rb.sc");
    tick(1'b0);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("rb_after%0d.hilo", c), {31'd0, HiLoWe}, 32'd0);
      check($sformatf("rb_after%0d.busy", c), {31'd0, MulDivBusy}, 32'd0);
      tick(1'b0);
    end

    // Twenty consecutive stalls saturate a 4-bit counter.
    load_use_rs8();
    for (int c = 0; c < 20; c++) tick(1'b1);
    #1;
    chk_sc("sat.sc");
    clr();
    tick(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
